alu_req_sequencer: RTL and testbench

- Shares one combinational ALU datapath (WIDTH-bit SrcA/SrcB, 3-bit ALUControl, Zero flag) between two requesters, e.g. the switch-entry front end and an auto-test pattern generator on the DE10-Lite.
- Accepts operations over valid/ready handshakes and arbitrates round-robin.
- Drives registered operands and opcode into the ALU, captures the result and Zero flag, and returns them with a per-requester done pulse.

---
 rtl/alu_seq_pkg.sv | 22 ++
 rtl/alu_req_sequencer_if.sv | 39 +++
 rtl/alu_req_sequencer_rr_arb2.sv | 21 ++
 rtl/alu_req_sequencer.sv | 93 +++++++++
 tb/tb_alu_req_sequencer.sv | 232 +++++++++++++++++++++++
 5 files changed

// File: rtl/alu_seq_pkg.sv
// Shared types and constants for the ALU request sequencer and the
// front ends that drive the ALU.
package alu_seq_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_EXEC = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    EXEC = ST_EXEC,
    RESP = ST_RESP
  } state_t;

  // ALUControl codes; the sequencer passes them through untouched.
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

endpackage

// File: rtl/alu_req_sequencer_if.sv
// Requester-side bus of the sequencer: two valid/ready request ports plus
// the shared result, per-requester done pulses and busy.
interface alu_req_sequencer_if #(
  parameter int WIDTH = 4
);

  logic             req0_valid;
  logic [WIDTH-1:0] req0_a;
  logic [WIDTH-1:0] req0_b;
  logic [2:0]       req0_op;
  logic             req0_ready;

  logic             req1_valid;
  logic [WIDTH-1:0] req1_a;
  logic [WIDTH-1:0] req1_b;
  logic [2:0]       req1_op;
  logic             req1_ready;

  logic [WIDTH-1:0] result;
  logic             result_zero;
  logic             done0;
  logic             done1;
  logic             busy;

  modport master (
    output req0_valid, req0_a, req0_b, req0_op,
    output req1_valid, req1_a, req1_b, req1_op,
    input  req0_ready, req1_ready,
    input  result, result_zero, done0, done1, busy
  );

  modport slave (
    input  req0_valid, req0_a, req0_b, req0_op,
    input  req1_valid, req1_a, req1_b, req1_op,
    output req0_ready, req1_ready,
    output result, result_zero, done0, done1, busy
  );

endinterface

// File: rtl/alu_req_sequencer_rr_arb2.sv
// Two-way round-robin arbiter: a lone requester wins, and under contention
// the requester that was not served last wins.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last_served,
  output logic [1:0] gnt
);

  always_comb begin
    // NOTE: assigning a default before the case keeps every path driven,
    // so no latch is inferred for combinational outputs.
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = last_served ? 2'b01 : 2'b10;
      default: gnt = 2'b00;
    endcase
  end

endmodule

// File: rtl/alu_req_sequencer.sv
// Time-shares one combinational ALU between two requesters: accept in IDLE,
// drive registered operands in EXEC, return result with a done pulse in RESP.
module alu_req_sequencer
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  alu_req_sequencer_if.slave bus,
  output logic [WIDTH-1:0] alu_src_a,
  output logic [WIDTH-1:0] alu_src_b,
  output logic [2:0]       alu_control,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_zero
);

  state_t           state;
  logic             last_served;
  logic             grant_id;
  logic [1:0]       gnt;
  logic [1:0]       ready;
  logic [1:0]       done_q;
  logic [WIDTH-1:0] result_q;
  logic             result_zero_q;

  rr_arb2 u_arb (
    .req         ({bus.req1_valid, bus.req0_valid}),
    .last_served (last_served),
    .gnt         (gnt)
  );

  // Ready is only offered in IDLE, and never while reset is being applied.
  always_comb begin
    ready = 2'b00;
    if (state == IDLE && !reset) ready = gnt;
  end

  assign bus.req0_ready  = ready[0];
  assign bus.req1_ready  = ready[1];
  assign bus.result      = result_q;
  assign bus.result_zero = result_zero_q;
  assign bus.done0       = done_q[0];
  assign bus.done1       = done_q[1];
  assign bus.busy        = (state != IDLE);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: every register here is a control or datapath flop, so all of
      // them get reset values; there is no storage array to leave unreset.
      state         <= IDLE;
      last_served   <= 1'b1;
      grant_id      <= 1'b0;
      alu_src_a     <= '0;
      alu_src_b     <= '0;
      alu_control   <= 3'b000;
      result_q      <= '0;
      result_zero_q <= 1'b0;
      done_q        <= 2'b00;
    end else begin
      done_q <= 2'b00;
      case (state)
        IDLE: begin
          if (|ready) begin
            grant_id <= ready[1];
            if (ready[1]) begin
              alu_src_a   <= bus.req1_a;
              alu_src_b   <= bus.req1_b;
              alu_control <= bus.req1_op;
            end else begin
              alu_src_a   <= bus.req0_a;
              alu_src_b   <= bus.req0_b;
              alu_control <= bus.req0_op;
            end
            state <= EXEC;
          end
        end
        EXEC: begin
          result_q         <= alu_result;
          result_zero_q    <= alu_zero;
          last_served      <= grant_id;
          done_q[grant_id] <= 1'b1;
          state            <= RESP;
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_req_sequencer.sv
// Scoreboard bench for alu_req_sequencer with a behavioural ALU attached to
// the operand outputs.
module tb_alu_req_sequencer;
  import alu_seq_pkg::*;

  localparam int WIDTH = 4;

  logic             clk = 1'b0;
  logic             reset;
  logic [WIDTH-1:0] alu_src_a;
  logic [WIDTH-1:0] alu_src_b;
  logic [2:0]       alu_control;
  logic [WIDTH-1:0] alu_result;
  logic             alu_zero;

  alu_req_sequencer_if #(.WIDTH(WIDTH)) bus ();

  alu_req_sequencer #(.WIDTH(WIDTH)) dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus),
    .alu_src_a   (alu_src_a),
    .alu_src_b   (alu_src_b),
    .alu_control (alu_control),
    .alu_result  (alu_result),
    .alu_zero    (alu_zero)
  );

  always #5 clk = ~clk;

  function automatic logic [WIDTH-1:0] alu_f(input logic [WIDTH-1:0] a,
                                             input logic [WIDTH-1:0] b,
                                             input logic [2:0] op);
    case (op)
      ALU_AND: return a & b;
      ALU_OR:  return a | b;
      ALU_ADD: return a + b;
      ALU_SUB: return a - b;
      ALU_SLT: return ($signed(a) < $signed(b)) ? WIDTH'(1) : WIDTH'(0);
      default: return '0;
    endcase
  endfunction

  assign alu_result = alu_f(alu_src_a, alu_src_b, alu_control);
  assign alu_zero   = (alu_result == '0);

  typedef struct {
    logic [1:0]       port_vec;
    logic [WIDTH-1:0] res;
    logic             zero;
    int               cyc;
  } exp_t;

  exp_t sb_q[$];
  int   done_port_log[$];
  int   done_cyc_log[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard: push on handshake, pop and compare on done.
  always @(negedge clk) begin
    if (reset) begin
      sb_q.delete();
    end else begin
      if (bus.req0_valid && bus.req0_ready) begin
        logic [WIDTH-1:0] r;
        r = alu_f(bus.req0_a, bus.req0_b, bus.req0_op);
        sb_q.push_back('{2'b01, r, (r == '0), cyc});
      end
      if (bus.req1_valid && bus.req1_ready) begin
        logic [WIDTH-1:0] r;
        r = alu_f(bus.req1_a, bus.req1_b, bus.req1_op);
        sb_q.push_back('{2'b10, r, (r == '0), cyc});
      end
      if (bus.done0 || bus.done1) begin
        done_port_log.push_back(bus.done1 ? 1 : 0);
        done_cyc_log.push_back(cyc);
        if (sb_q.size() == 0) begin
          check("done_unexpected", {30'b0, bus.done1, bus.done0}, 32'd0);
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          check("done_port", {30'b0, bus.done1, bus.done0}, {30'b0, e.port_vec});
          check("sb_result", {28'b0, bus.result}, {28'b0, e.res});
          check("sb_zero", {31'b0, bus.result_zero}, {31'b0, e.zero});
          check("latency", cyc - e.cyc, 32'd2);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    bus.req0_valid = 1'b1; bus.req0_a = 4'd1; bus.req0_b = 4'd1; bus.req0_op = ALU_ADD;
    bus.req1_valid = 1'b1; bus.req1_a = 4'd2; bus.req1_b = 4'd2; bus.req1_op = ALU_ADD;
    repeat (2) step();

    check("rst_busy", {31'b0, bus.busy}, 32'd0);
    check("rst_ready", {30'b0, bus.req1_ready, bus.req0_ready}, 32'd0);
    check("rst_src_a", {28'b0, alu_src_a}, 32'd0);
    check("rst_src_b", {28'b0, alu_src_b}, 32'd0);
    check("rst_ctrl", {29'b0, alu_control}, 32'd0);
    check("rst_result", {28'b0, bus.result}, 32'd0);
    check("rst_zero", {31'b0, bus.result_zero}, 32'd0);
    check("rst_done", {30'b0, bus.done1, bus.done0}, 32'd0);

    reset = 1'b0;
    #1;
    check("first_ready0", {31'b0, bus.req0_ready}, 32'd1);
    check("first_ready1", {31'b0, bus.req1_ready}, 32'd0);

    // Contention: both held valid, grants must alternate every 3 cycles.
    for (int i = 0; i < 60 && done_port_log.size() < 4; i++) begin
      @(negedge clk);
      #1;
    end
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    check("cont_count", done_port_log.size(), 32'd4);
    for (int i = 0; i < done_port_log.size() && i < 4; i++)
      check("cont_order", done_port_log[i], i % 2);
    for (int i = 1; i < done_cyc_log.size() && i < 4; i++)
      check("cont_period", done_cyc_log[i] - done_cyc_log[i-1], 32'd3);
    repeat (2) step();

    // Single op on port 0.
    bus.req0_a = 4'd3; bus.req0_b = 4'd4; bus.req0_op = ALU_ADD; bus.req0_valid = 1'b1;
    #1;
    check("p0_ready", {30'b0, bus.req1_ready, bus.req0_ready}, 32'b01);
    check("p0_busy_idle", {31'b0, bus.busy}, 32'd0);
    step();
    bus.req0_valid = 1'b0;
    check("p0_src_a", {28'b0, alu_src_a}, 32'd3);
    check("p0_src_b", {28'b0, alu_src_b}, 32'd4);
    check("p0_ctrl", {29'b0, alu_control}, {29'b0, ALU_ADD});
    check("p0_busy_exec", {31'b0, bus.busy}, 32'd1);
    check("p0_ready_exec", {30'b0, bus.req1_ready, bus.req0_ready}, 32'd0);
    check("p0_done_exec", {30'b0, bus.done1, bus.done0}, 32'd0);
    step();
    check("p0_done", {30'b0, bus.done1, bus.done0}, 32'b01);
    check("p0_result", {28'b0, bus.result}, 32'd7);
    check("p0_zero", {31'b0, bus.result_zero}, 32'd0);
    step();
    check("p0_done_clr", {30'b0, bus.done1, bus.done0}, 32'd0);
    check("p0_busy_end", {31'b0, bus.busy}, 32'd0);

    // Zero flag and wrap on port 1.
    bus.req1_a = 4'd9; bus.req1_b = 4'd7; bus.req1_op = ALU_ADD; bus.req1_valid = 1'b1;
    #1;
    check("p1_ready", {30'b0, bus.req1_ready, bus.req0_ready}, 32'b10);
    step();
    bus.req1_valid = 1'b0;
    step();
    check("p1_done", {30'b0, bus.done1, bus.done0}, 32'b10);
    check("p1_result", {28'b0, bus.result}, 32'd0);
    check("p1_zero", {31'b0, bus.result_zero}, 32'd1);
    repeat (3) step();
    check("hold_result", {28'b0, bus.result}, 32'd0);
    check("hold_zero", {31'b0, bus.result_zero}, 32'd1);
    check("hold_src_a", {28'b0, alu_src_a}, 32'd9);

    // Backpressure: port 1 raises valid during EXEC of a port 0 op.
    bus.req0_a = 4'd5; bus.req0_b = 4'd6; bus.req0_valid = 1'b1;
    step();
    bus.req0_valid = 1'b0;
    bus.req1_a = 4'd8; bus.req1_b = 4'd7; bus.req1_op = ALU_ADD; bus.req1_valid = 1'b1;
    #1;
    check("bp_ready_exec", {31'b0, bus.req1_ready}, 32'd0);
    step();
    check("bp_ready_resp", {31'b0, bus.req1_ready}, 32'd0);
    check("bp_p0_result", {28'b0, bus.result}, 32'd11);
    step();
    check("bp_ready_idle", {31'b0, bus.req1_ready}, 32'd1);
    step();
    bus.req1_valid = 1'b0;
    check("bp_src_a", {28'b0, alu_src_a}, 32'd8);
    check("bp_src_b", {28'b0, alu_src_b}, 32'd7);
    step();
    check("bp_done", {30'b0, bus.done1, bus.done0}, 32'b10);
    check("bp_result", {28'b0, bus.result}, 32'd15);
    step();

    // Reset during EXEC drops the op.
    bus.req0_a = 4'd2; bus.req0_b = 4'd3; bus.req0_valid = 1'b1;
    step();
    bus.req0_valid = 1'b0;
    reset = 1'b1;
    step();
    check("mid_done", {30'b0, bus.done1, bus.done0}, 32'd0);
    check("mid_busy", {31'b0, bus.busy}, 32'd0);
    check("mid_src_a", {28'b0, alu_src_a}, 32'd0);
    check("mid_result", {28'b0, bus.result}, 32'd0);
    reset = 1'b0;
    step();
    check("mid_no_done", {30'b0, bus.done1, bus.done0}, 32'd0);
    bus.req0_a = 4'd6; bus.req0_b = 4'd1; bus.req0_valid = 1'b1;
    step();
    bus.req0_valid = 1'b0;
    step();
    check("post_done", {30'b0, bus.done1, bus.done0}, 32'b01);
    check("post_result", {28'b0, bus.result}, 32'd7);

    repeat (3) step();
    check("sb_drained", sb_q.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
